// File: rtl/mac_tree_acc.sv
// rtl/mac_tree_acc.sv - streaming dot-product engine: per-lane multiply, registered adder tree, beat accumulator.
// Optional MAC_TREE_ACC_SAT_EN clamps the result to the OUT_WIDTH range instead of truncating.
module mac_tree_acc #(
    parameter int LANES        = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACT_WIDTH    = 4,
    parameter int OUT_WIDTH    = 16,
    parameter int MAX_BEATS    = 16,
    parameter int SIGNED       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    output logic                              i_ready,
    input  logic                              i_last,
    input  logic [LANES*WEIGHT_WIDTH-1:0]     i_weights_flat,
    input  logic [LANES*ACT_WIDTH-1:0]        i_acts_flat,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [OUT_WIDTH-1:0]              o_result,
    output logic                              o_err
);
    localparam int   D  = $clog2(LANES);
    localparam int   PW = WEIGHT_WIDTH + ACT_WIDTH;
    localparam int   CW = $clog2(MAX_BEATS);
    localparam int   TW = PW + D;
    localparam int   AW = TW + CW;
    localparam logic SX = (SIGNED != 0);

    logic stall;
    logic accept;
    assign stall   = o_valid & ~o_ready;
    assign i_ready = ~stall;
    assign accept  = i_valid & ~stall;

    // Operands are widened to PW bits first so the low PW bits of the product are exact in both modes.
    function automatic logic [PW-1:0] lane_mul(input logic [WEIGHT_WIDTH-1:0] w,
                                               input logic [ACT_WIDTH-1:0]    a);
        logic [PW-1:0] wx;
        logic [PW-1:0] ax;
        wx = {{ACT_WIDTH{SX & w[WEIGHT_WIDTH-1]}}, w};
        ax = {{WEIGHT_WIDTH{SX & a[ACT_WIDTH-1]}}, a};
        return wx * ax;
    endfunction

    logic [CW-1:0] beat_cnt;
    logic          at_max;
    logic          eff_last;
    logic          forced;
    assign at_max   = (beat_cnt == CW'(MAX_BEATS - 1));
    assign eff_last = i_last | at_max;
    assign forced   = at_max & ~i_last;

    // Tag bit l travels alongside tree level l (bit 0 = product register).
    logic [D:0] tag_v;
    logic [D:0] tag_l;
    logic [D:0] tag_f;
    logic [D:0] tag_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            tag_v    <= '0;
            tag_l    <= '0;
            tag_f    <= '0;
            tag_e    <= '0;
        end else if (!stall) begin
            tag_v <= {tag_v[D-1:0], accept};
            tag_l <= {tag_l[D-1:0], eff_last};
            tag_f <= {tag_f[D-1:0], (beat_cnt == '0)};
            tag_e <= {tag_e[D-1:0], forced};
            if (accept) begin
                beat_cnt <= eff_last ? '0 : beat_cnt + CW'(1);
            end
        end
    end

    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int W = PW + l;
        localparam int N = LANES >> l;
        logic [W-1:0] node [N];

        if (l == 0) begin : g_mul
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < N; i++) node[i] <= '0;
                end else if (!stall) begin
                    for (int i = 0; i < N; i++) begin
                        node[i] <= lane_mul(i_weights_flat[i*WEIGHT_WIDTH +: WEIGHT_WIDTH],
                                            i_acts_flat[i*ACT_WIDTH +: ACT_WIDTH]);
                    end
                end
            end
        end else begin : g_add
            function automatic logic [W-1:0] grow(input logic [W-2:0] x);
                return {SX & x[W-2], x};
            endfunction

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < N; i++) node[i] <= '0;
                end else if (!stall) begin
                    for (int i = 0; i < N; i++) begin
                        node[i] <= grow(g_lvl[l-1].node[2*i]) + grow(g_lvl[l-1].node[2*i+1]);
                    end
                end
            end
        end
    end

    logic [TW-1:0] tree_sum;
    logic [AW-1:0] tree_ext;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    assign tree_sum = g_lvl[D].node[0];
    assign tree_ext = {{CW{SX & tree_sum[TW-1]}}, tree_sum};
    assign acc_next = tag_f[D] ? tree_ext : acc + tree_ext;

    logic [OUT_WIDTH-1:0] res_next;
    if (OUT_WIDTH >= AW) begin : g_extend
        if (SIGNED != 0) begin : g_s
            assign res_next = OUT_WIDTH'($signed(acc_next));
        end else begin : g_u
            assign res_next = OUT_WIDTH'(acc_next);
        end
    end else begin : g_narrow
`ifdef MAC_TREE_ACC_SAT_EN
        if (SIGNED != 0) begin : g_s
            logic [AW-OUT_WIDTH:0] hi;
            logic                  ovf;
            assign hi  = acc_next[AW-1:OUT_WIDTH-1];
            assign ovf = ~(&hi | ~|hi);
            assign res_next = !ovf         ? acc_next[OUT_WIDTH-1:0] :
                              acc_next[AW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                               {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else begin : g_u
            assign res_next = (|acc_next[AW-1:OUT_WIDTH]) ? '1 : acc_next[OUT_WIDTH-1:0];
        end
`else
        assign res_next = acc_next[OUT_WIDTH-1:0];
`endif
    end

    // A completing vector can only land when the output slot is free or being consumed this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_result <= '0;
        end else if (!stall) begin
            if (tag_v[D]) begin
                acc <= acc_next;
            end
            if (tag_v[D] && tag_l[D]) begin
                o_valid  <= 1'b1;
                o_err    <= tag_e[D];
                o_result <= res_next;
            end else begin
                o_valid <= 1'b0;
                o_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_tree_acc.sv
// tb/tb_mac_tree_acc.sv - randomized and directed checks of mac_tree_acc against an arithmetic dot-product model.
module tb_mac_tree_acc;
    localparam int MB = 16;

    typedef struct {
        logic [15:0] r;
        logic        e;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic        i_last;
    logic [31:0] i_w;
    logic [31:0] i_a;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_result;
    logic        o_err;

    logic        u_valid;
    logic        u16_iready, u16_valid, u16_err;
    logic [15:0] u16_result;
    logic        u8_iready, u8_valid, u8_err;
    logic [7:0]  u8_result;

    assign u_valid = i_valid & i_ready;

    always #5 clk = ~clk;

    mac_tree_acc dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_last(i_last),
        .i_weights_flat(i_w), .i_acts_flat(i_a), .o_valid(o_valid), .o_ready(o_ready),
        .o_result(o_result), .o_err(o_err)
    );

    mac_tree_acc #(.SIGNED(0), .OUT_WIDTH(16)) dut_u16 (
        .clk(clk), .rst(rst), .i_valid(u_valid), .i_ready(u16_iready), .i_last(i_last),
        .i_weights_flat(i_w), .i_acts_flat(i_a), .o_valid(u16_valid), .o_ready(1'b1),
        .o_result(u16_result), .o_err(u16_err)
    );

    mac_tree_acc #(.SIGNED(0), .OUT_WIDTH(8)) dut_u8 (
        .clk(clk), .rst(rst), .i_valid(u_valid), .i_ready(u8_iready), .i_last(i_last),
        .i_weights_flat(i_w), .i_acts_flat(i_a), .o_valid(u8_valid), .o_ready(1'b1),
        .o_result(u8_result), .o_err(u8_err)
    );

`ifdef MAC_TREE_ACC_SAT_EN
    localparam logic [7:0] U8_EXP = 8'd255;
`else
    localparam logic [7:0] U8_EXP = 8'd8;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    res_t exp_q[$];
    res_t got_q[$];
    int   m_acc  = 0;
    int   m_cnt  = 0;

    logic [15:0] u16_r = '0;
    logic        u16_e = 1'b0;
    logic [7:0]  u8_r  = '0;
    logic        u8_e  = 1'b0;
    int          u_n   = 0;

    function automatic int dot(input logic [31:0] w, input logic [31:0] a);
        int s = 0;
        int wi;
        int ai;
        for (int k = 0; k < 8; k++) begin
            wi = $signed(w[k*4 +: 4]);
            ai = $signed(a[k*4 +: 4]);
            s += wi * ai;
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            res_t e;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result got=%0d err=%0b required=none", o_result, o_err);
            end else begin
                e = exp_q.pop_front();
                if (o_result !== e.r || o_err !== e.e) begin
                    n_fail++;
                    $display("FAIL result got=%0d err=%0b required=%0d err=%0b", o_result, o_err, e.r, e.e);
                end
            end
            got_q.push_back('{o_result, o_err});
        end
    end

    always @(negedge clk) begin
        if (u16_valid) begin
            u16_r = u16_result;
            u16_e = u16_err;
            u_n++;
        end
        if (u8_valid) begin
            u8_r = u8_result;
            u8_e = u8_err;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [31:0] w, input logic [31:0] a, input logic last);
        int  t;
        bit  ok;
        bit  err;
        i_w = w; i_a = a; i_last = last; i_valid = 1'b1;
        t = 0; ok = 1'b0;
        forever begin
            @(negedge clk);
            if (i_ready) begin
                ok = 1'b1;
                break;
            end
            t++;
            if (t > 300) begin
                n_chk++; n_fail++;
                $display("FAIL accept_timeout waited=%0d cycles required=accept", t);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            m_acc += dot(w, a);
            m_cnt++;
            if (last || m_cnt == MB) begin
                err = (m_cnt == MB) && !last;
                exp_q.push_back('{16'(m_acc), err});
                m_acc = 0;
                m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_w = $urandom; i_a = $urandom; i_last = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 600) begin
            @(posedge clk);
            #1;
            t++;
        end
        idle(2);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk += 4;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got=%0b required=0", o_valid); end
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_o_err got=%0b required=0", o_err); end
        if (o_result !== 16'd0) begin n_fail++; $display("FAIL reset_o_result got=%0d required=0", o_result); end
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready got=%0b required=1", i_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int lat = 0;
        send_beat(32'h1111_1111, 32'h1111_1111, 1'b1);
        forever begin
            @(negedge clk);
            if (o_valid || lat > 20) break;
            @(posedge clk);
            lat++;
        end
        n_chk++;
        if (lat !== 4) begin n_fail++; $display("FAIL latency got=%0d required=4", lat); end
        @(posedge clk);
        #1;
        drain();
        n_chk++;
        if (got_q.size() == 0 || got_q[$].r !== 16'd8 || got_q[$].e !== 1'b0) begin
            n_fail++; $display("FAIL ones_result got_count=%0d required=8 err=0", got_q.size());
        end
    endtask

    task automatic test_signed_min();
        for (int b = 0; b < 4; b++) send_beat(32'h8888_8888, 32'h8888_8888, (b == 3));
        drain();
        n_chk++;
        if (got_q.size() == 0 || got_q[$].r !== 16'd2048 || got_q[$].e !== 1'b0) begin
            n_fail++; $display("FAIL signed_min got=%0d required=2048", got_q.size() ? got_q[$].r : 16'hx);
        end
    endtask

    task automatic test_unsigned();
        int n0 = u_n;
        send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();
        n_chk += 4;
        if (u_n != n0 + 1) begin n_fail++; $display("FAIL unsigned_count got=%0d required=%0d", u_n, n0 + 1); end
        if (u16_r !== 16'd1800 || u16_e !== 1'b0) begin n_fail++; $display("FAIL unsigned16 got=%0d required=1800", u16_r); end
        if (u8_r !== U8_EXP || u8_e !== 1'b0) begin n_fail++; $display("FAIL unsigned8 got=%0d required=%0d", u8_r, U8_EXP); end
        if (u16_iready !== 1'b1 || u8_iready !== 1'b1) begin n_fail++; $display("FAIL unsigned_ready got=%0b%0b required=11", u16_iready, u8_iready); end
    endtask

    task automatic test_back_to_back();
        int n0 = got_q.size();
        o_ready = 1'b0;
        fork
            begin
                send_beat($urandom, $urandom, 1'b1);
                send_beat($urandom, $urandom, 1'b0);
                send_beat($urandom, $urandom, 1'b1);
                send_beat($urandom, $urandom, 1'b1);
            end
            begin
                int          t = 0;
                logic [15:0] hold_r;
                logic        hold_e;
                do begin
                    @(negedge clk);
                    t++;
                end while (!o_valid && t < 100);
                hold_r = o_result;
                hold_e = o_err;
                repeat (10) begin
                    @(negedge clk);
                    n_chk++;
                    if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== hold_r || o_err !== hold_e) begin
                        n_fail++;
                        $display("FAIL stall_hold ready=%0b valid=%0b result=%0d required ready=0 valid=1 result=%0d",
                                 i_ready, o_valid, o_result, hold_r);
                    end
                end
                @(posedge clk);
                #1;
                o_ready = 1'b1;
            end
        join
        drain();
        n_chk++;
        if (got_q.size() != n0 + 3) begin n_fail++; $display("FAIL stall_count got=%0d required=%0d", got_q.size(), n0 + 3); end
    endtask

    task automatic test_max_beats();
        int n0 = got_q.size();
        for (int b = 0; b < 17; b++) send_beat(32'h1111_1111, 32'h1111_1111, 1'b0);
        send_beat(32'h1111_1111, 32'h1111_1111, 1'b1);
        drain();
        n_chk += 2;
        if (got_q.size() != n0 + 2) begin
            n_fail++; $display("FAIL max_count got=%0d required=%0d", got_q.size(), n0 + 2);
        end else begin
            if (got_q[n0].r !== 16'd128 || got_q[n0].e !== 1'b1) begin
                n_fail++; $display("FAIL max_forced got=%0d err=%0b required=128 err=1", got_q[n0].r, got_q[n0].e);
            end
            if (got_q[n0+1].r !== 16'd16 || got_q[n0+1].e !== 1'b0) begin
                n_fail++; $display("FAIL max_next got=%0d err=%0b required=16 err=0", got_q[n0+1].r, got_q[n0+1].e);
            end
        end
    endtask

    task automatic test_reset_abort();
        int n0 = got_q.size();
        send_beat(32'h1111_1111, 32'h1111_1111, 1'b0);
        send_beat(32'h1111_1111, 32'h1111_1111, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        n_chk++;
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%0b required=1", i_ready); end
        @(posedge clk);
        #1;
        idle(8);
        n_chk++;
        if (got_q.size() != n0) begin n_fail++; $display("FAIL abort_leak got=%0d required=%0d", got_q.size(), n0); end
        send_beat(32'h1111_1111, 32'h1111_1111, 1'b1);
        drain();
        n_chk++;
        if (got_q.size() != n0 + 1 || got_q[$].r !== 16'd8) begin
            n_fail++; $display("FAIL abort_next count=%0d required=%0d value 8", got_q.size(), n0 + 1);
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int v = 0; v < 40; v++) begin
                    int len = $urandom_range(1, 17);
                    int nb  = (len == 17) ? MB : len;
                    for (int b = 0; b < nb; b++) begin
                        send_beat($urandom, $urandom, (len != 17) && (b == nb - 1));
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    o_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        o_ready = 1'b1;
        drain();
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_w = '0; i_a = '0; o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_latency();
        test_signed_min();
        test_unsigned();
        test_back_to_back();
        test_max_beats();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_tree_acc.md
MAC_TREE_ACC -- requirements
Module: mac_tree_acc

Interface
REQ-001 SHALL provide parameter LANES, default 8, products per beat; power of two, 2..128.
REQ-002 SHALL provide parameter WEIGHT_WIDTH, default 4, weight bits per lane.
REQ-003 SHALL provide parameter ACT_WIDTH, default 4, activation bits per lane.
REQ-004 SHALL provide parameter OUT_WIDTH, default 16, result bits.
REQ-005 SHALL provide parameter MAX_BEATS, default 16, maximum beats per vector; power of two, at least 2.
REQ-006 SHALL provide parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned operands.
REQ-007 SHALL provide port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-008 SHALL provide port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL provide port i_valid, input, 1 bit, beat valid.
REQ-010 SHALL provide port i_ready, output, 1 bit, beat accepted when i_valid and i_ready are both high.
REQ-011 SHALL provide port i_last, input, 1 bit, final beat of the vector.
REQ-012 SHALL provide port i_weights_flat, input, LANES*WEIGHT_WIDTH bits; lane k occupies bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-013 SHALL provide port i_acts_flat, input, LANES*ACT_WIDTH bits; lane k occupies bits [k*ACT_WIDTH +: ACT_WIDTH].
REQ-014 SHALL provide port o_valid, output, 1 bit, result valid.
REQ-015 SHALL provide port o_ready, input, 1 bit, result consumed when o_valid and o_ready are both high.
REQ-016 SHALL provide port o_result, output, OUT_WIDTH bits, dot-product result.
REQ-017 SHALL provide port o_err, output, 1 bit; high with o_valid when the vector was closed implicitly at MAX_BEATS.

Function
REQ-018 SHALL compute per lane product = weight*act, PW = WEIGHT_WIDTH+ACT_WIDTH bits, signed or unsigned per SIGNED.
REQ-019 SHALL sum products in a registered binary adder tree.
- D = log2(LANES) register stages.
- Each stage grows width by 1 bit; no overflow is possible inside the tree.
REQ-020 SHALL hold an accumulator of AW = PW + log2(LANES) + log2(MAX_BEATS) bits.
- First beat of a vector: acc = tree sum.
- Later beats: acc = acc + tree sum.
REQ-021 SHALL define stall = o_valid AND NOT o_ready; i_ready = NOT stall; every pipeline register, the valid/last/first tags and the beat counter SHALL hold while stall is high.
REQ-022 SHALL assert o_valid exactly D+1 cycles after the accepted last beat when no stall occurs; o_result and o_err SHALL stay stable while o_valid is high and o_ready is low.
REQ-023 SHALL accept back-to-back vectors with no bubble; a vector's first beat may follow the previous last beat on the next cycle.
REQ-024 SHALL count accepted beats per vector; on the MAX_BEATS-th beat without i_last, SHALL treat that beat as last and tag o_err=1 for that result; the next beat starts a new vector.
REQ-025 SHALL clear o_valid after a handshake unless a new result completes in the same cycle; in that case o_valid stays high with the new result.
REQ-026 SHALL ignore i_weights_flat, i_acts_flat and i_last when i_valid is low; cycles with no accepted beat add nothing to the accumulator.
REQ-027 SHALL form the result by truncating the accumulator to its low OUT_WIDTH bits when OUT_WIDTH < AW, and by sign-extending (SIGNED=1) or zero-extending (SIGNED=0) it when OUT_WIDTH >= AW.

Reset
REQ-028 SHALL on rst clear o_valid, o_err, o_result, accumulator, beat counter and all pipeline valid tags to 0; i_ready SHALL read 1 in the cycle after rst deasserts.
REQ-029 SHALL discard any partial vector in flight when rst is asserted mid-operation; the first beat accepted after reset SHALL start a new vector.

Configuration
REQ-030 SHALL, with macro MAC_TREE_ACC_SAT_EN defined, clamp to the OUT_WIDTH range whenever AW > OUT_WIDTH.
- SIGNED=1: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- SIGNED=0: clamp to [0, 2^OUT_WIDTH-1].
- Without the macro, REQ-027 truncation applies and no saturation logic is built.

Verification
REQ-031 SHALL cover: LANES=8, all w=1, a=1, one beat with i_last -> o_result=8, o_valid high 4 cycles after acceptance, o_err=0.
REQ-032 SHALL cover: SIGNED=1, all w=-8, a=-8, 4 beats, last on beat 4 -> o_result=2048.
REQ-033 SHALL cover: SIGNED=0, all w=15, a=15, 1 beat -> o_result=1800; then OUT_WIDTH=8 -> 255 with MAC_TREE_ACC_SAT_EN, 8 without.
REQ-034 SHALL cover: o_ready held low 10 cycles with 3 vectors queued -> i_ready low, result stable, all 3 results delivered in order with none lost.
REQ-035 SHALL cover: 17 beats of w=1, a=1 with i_last never asserted, MAX_BEATS=16 -> first result 128 with o_err=1; beat 17 opens a new vector.
REQ-036 SHALL cover: rst pulsed after beat 2 of 4 -> no output for the aborted vector; the next 1-beat vector of ones -> 8.
